// File: rtl/hub75_pkg.sv
// HUB75 capture shared definitions.
// FSM encoding and rgb lane ordering.
package hub75_pkg;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_LATCH = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  localparam int RGB_W  = 6;
  localparam int R0_BIT = 5;
  localparam int G0_BIT = 4;
  localparam int B0_BIT = 3;
  localparam int R1_BIT = 2;
  localparam int G1_BIT = 1;
  localparam int B1_BIT = 0;

endpackage

// File: rtl/hub75_capture_edge_detect.sv
// Single-bit edge detector.
// chg is high for one cycle whenever d differs from its last sample.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic chg
);

  logic q_q;
  logic q_d;

  assign q_d = d;
  assign chg = d ^ q_q;

  // previous-cycle sample of the input
  always_ff @(posedge clk) begin
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

endmodule

// File: rtl/hub75_capture.sv
// HUB75 panel bus sniffer.
// Captures shifted rows, latch address and oe dwell time.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLUMNS = 32,
  parameter int DWELL_W = 16,
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = $clog2(COLUMNS) + 1,
  localparam int RW = RGB_W * COLUMNS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               oclk,
  input  logic               lat,
  input  logic               oe,
  input  logic [AW-1:0]      addr,
  input  logic [RGB_W-1:0]   rgb,
  output logic [RW-1:0]      row_data,
  output logic [AW-1:0]      row_idx,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [DWELL_W-1:0] dwell,
  output logic               dwell_valid,
  output logic               err_short,
  output logic               err_overrun,
  output logic               err_protocol
);

  localparam logic [CW-1:0] COL_FULL = CW'(COLUMNS);
  localparam logic [CW-1:0] COL_SAT  = CW'(COLUMNS + 1);

  logic oclk_chg, lat_chg, oe_chg;
  logic oclk_rise, lat_fall, lat_rise, oe_fall, oe_rise;

  edge_detect #(.RST_VAL(1'b0)) u_oclk (
    .clk(clk), .rst(rst), .d(oclk), .chg(oclk_chg)
  );
  edge_detect #(.RST_VAL(1'b1)) u_lat (
    .clk(clk), .rst(rst), .d(lat), .chg(lat_chg)
  );
  edge_detect #(.RST_VAL(1'b1)) u_oe (
    .clk(clk), .rst(rst), .d(oe), .chg(oe_chg)
  );

  assign oclk_rise = oclk_chg & oclk;
  assign lat_rise  = lat_chg & lat;
  assign lat_fall  = lat_chg & ~lat;
  assign oe_rise   = oe_chg & oe;
  assign oe_fall   = oe_chg & ~oe;

  state_e             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [RW-1:0]      sr_q, sr_d;
  logic [RW-1:0]      row_data_q, row_data_d;
  logic [AW-1:0]      row_idx_q, row_idx_d;
  logic               row_valid_q, row_valid_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               dwell_valid_q, dwell_valid_d;
  logic               err_short_q, err_short_d;
  logic               err_overrun_q, err_overrun_d;
  logic               err_protocol_q, err_protocol_d;

  // next-state: shifting, row latch handshake, dwell timing, errors
  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    sr_d           = sr_q;
    row_data_d     = row_data_q;
    row_idx_d      = row_idx_q;
    row_valid_d    = row_valid_q;
    cnt_d          = cnt_q;
    dwell_d        = dwell_q;
    dwell_valid_d  = 1'b0;
    err_short_d    = err_short_q;
    err_overrun_d  = err_overrun_q;
    err_protocol_d = err_protocol_q;

    if (row_valid_q && row_ready) row_valid_d = 1'b0;
    if (oe_fall && !lat) err_protocol_d = 1'b1;

    unique case (state_q)
      ST_SHIFT: begin
        if (oclk_rise) begin
          sr_d = {sr_q[RW-RGB_W-1:0], rgb};
          if (col_q != COL_SAT) col_d = col_q + CW'(1);
        end
        if (lat_fall) begin
          state_d = ST_LATCH;
          if (col_q == COL_FULL) begin
            row_data_d  = sr_q;
            row_idx_d   = addr;
            row_valid_d = 1'b1;
            // same-cycle acceptance frees the slot
            if (row_valid_q && !row_ready) err_overrun_d = 1'b1;
          end else begin
            err_short_d = 1'b1;
          end
        end else if (oe_fall && lat) begin
          state_d = ST_DWELL;
          cnt_d   = DWELL_W'(1);
        end
      end
      ST_LATCH: begin
        if (oclk_rise) err_protocol_d = 1'b1;
        if (lat_rise) begin
          col_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_DWELL: begin
        if (oclk_rise || lat_fall) err_protocol_d = 1'b1;
        if (oe_rise) begin
          dwell_d       = cnt_q;
          dwell_valid_d = 1'b1;
          state_d       = ST_SHIFT;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_SHIFT;
      col_q          <= '0;
      sr_q           <= '0;
      row_data_q     <= '0;
      row_idx_q      <= '0;
      row_valid_q    <= 1'b0;
      cnt_q          <= '0;
      dwell_q        <= '0;
      dwell_valid_q  <= 1'b0;
      err_short_q    <= 1'b0;
      err_overrun_q  <= 1'b0;
      err_protocol_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      sr_q           <= sr_d;
      row_data_q     <= row_data_d;
      row_idx_q      <= row_idx_d;
      row_valid_q    <= row_valid_d;
      cnt_q          <= cnt_d;
      dwell_q        <= dwell_d;
      dwell_valid_q  <= dwell_valid_d;
      err_short_q    <= err_short_d;
      err_overrun_q  <= err_overrun_d;
      err_protocol_q <= err_protocol_d;
    end
  end

  assign row_data     = row_data_q;
  assign row_idx      = row_idx_q;
  assign row_valid    = row_valid_q;
  assign dwell        = dwell_q;
  assign dwell_valid  = dwell_valid_q;
  assign err_short    = err_short_q;
  assign err_overrun  = err_overrun_q;
  assign err_protocol = err_protocol_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Testbench for hub75_capture.
// Vector table, random rows and hand-written corner sequences.
module tb_hub75_capture;

  localparam int ROWS    = 8;
  localparam int COLUMNS = 32;
  localparam int DWELL_W = 16;

  logic         clk = 0;
  logic         rst = 0;
  logic         oclk = 0;
  logic         lat = 1;
  logic         oe = 1;
  logic [2:0]   addr = '0;
  logic [5:0]   rgb = '0;
  logic         row_ready = 0;
  logic [191:0] row_data;
  logic [2:0]   row_idx;
  logic         row_valid;
  logic [15:0]  dwell;
  logic         dwell_valid;
  logic         err_short, err_overrun, err_protocol;

  int nchk = 0;
  int nerr = 0;
  int npulse = 0;
  bit [5:0] hist[$];

  hub75_capture #(.ROWS(ROWS), .COLUMNS(COLUMNS), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .oclk(oclk), .lat(lat), .oe(oe),
    .addr(addr), .rgb(rgb), .row_data(row_data), .row_idx(row_idx),
    .row_valid(row_valid), .row_ready(row_ready), .dwell(dwell),
    .dwell_valid(dwell_valid), .err_short(err_short),
    .err_overrun(err_overrun), .err_protocol(err_protocol)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dwell_valid) npulse++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // model: row is the last COLUMNS values shifted, first one in MSBs
  function automatic logic [191:0] exp_row();
    logic [191:0] r = '0;
    int n = hist.size();
    for (int i = 0; i < COLUMNS; i++)
      if (n - COLUMNS + i >= 0)
        r[(COLUMNS-1-i)*6 +: 6] = hist[n-COLUMNS+i];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 0; oclk = 0; lat = 1; oe = 1; row_ready = 0;
    @(negedge clk);
    rst = 1;
    hist.delete();
  endtask

  task automatic shift1(logic [5:0] v);
    @(negedge clk);
    rgb = v; oclk = 1;
    @(negedge clk);
    oclk = 0;
    hist.push_back(v);
  endtask

  task automatic lat_lo(logic [2:0] a);
    @(negedge clk);
    addr = a; lat = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic lat_hi();
    @(negedge clk);
    lat = 1;
    @(negedge clk);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_data"}, row_data, '0);
    chk({tag, "_idx"}, {189'b0, row_idx}, '0);
    chk({tag, "_valid"}, {191'b0, row_valid}, '0);
    chk({tag, "_dwell"}, {176'b0, dwell}, '0);
    chk({tag, "_dvalid"}, {191'b0, dwell_valid}, '0);
    chk({tag, "_errs"}, {189'b0, err_short, err_overrun, err_protocol}, '0);
  endtask

  task automatic dwell_run(int n);
    int p0 = npulse;
    int e = (n > 65535) ? 65535 : n;
    @(negedge clk);
    oe = 0;
    repeat (n) @(negedge clk);
    oe = 1;
    @(posedge clk);
    #1;
    chk("dwell_valid_hi", {191'b0, dwell_valid}, 192'd1);
    chk("dwell_value", {176'b0, dwell}, 192'(e));
    @(negedge clk);
    @(posedge clk);
    #1;
    chk("dwell_valid_lo", {191'b0, dwell_valid}, '0);
    chk("dwell_pulses", 192'(npulse - p0), 192'd1);
  endtask

  typedef struct {
    int         pulses;
    logic [2:0] a;
    bit         ready;
    bit         ev;
    bit         es;
  } vec_t;

  vec_t tbl[6];
  logic [191:0] er;

  initial begin
    tbl[0] = '{32, 3'd3, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{31, 3'd5, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{33, 3'd1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{32, 3'd7, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{0,  3'd2, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{32, 3'd0, 1'b1, 1'b1, 1'b0};

    // reset state
    rst = 0;
    @(posedge clk);
    #1;
    chk_zero("reset");
    do_reset();

    // full row with rgb = column index
    for (int i = 0; i < COLUMNS; i++) shift1(6'(i));
    er = exp_row();
    lat_lo(3'd3);
    chk("basic_valid", {191'b0, row_valid}, 192'd1);
    chk("basic_idx", {189'b0, row_idx}, 192'd3);
    chk("basic_data", row_data, er);
    chk("basic_errs", {189'b0, err_short, err_overrun, err_protocol}, '0);
    lat_hi();

    // vector table
    foreach (tbl[k]) begin
      do_reset();
      row_ready = tbl[k].ready;
      for (int i = 0; i < tbl[k].pulses; i++) shift1(6'($urandom));
      er = exp_row();
      lat_lo(tbl[k].a);
      chk($sformatf("tbl%0d_valid", k), {191'b0, row_valid}, 192'(tbl[k].ev));
      chk($sformatf("tbl%0d_short", k), {191'b0, err_short}, 192'(tbl[k].es));
      if (tbl[k].ev) begin
        chk($sformatf("tbl%0d_data", k), row_data, er);
        chk($sformatf("tbl%0d_idx", k), {189'b0, row_idx}, 192'(tbl[k].a));
      end
      lat_hi();
      row_ready = 0;
    end

    // random rows, consumer always ready
    do_reset();
    row_ready = 1;
    for (int r = 0; r < 6; r++) begin
      logic [2:0] a = 3'($urandom);
      for (int i = 0; i < COLUMNS; i++) shift1(6'($urandom));
      er = exp_row();
      lat_lo(a);
      chk($sformatf("rnd%0d_valid", r), {191'b0, row_valid}, 192'd1);
      chk($sformatf("rnd%0d_idx", r), {189'b0, row_idx}, 192'(a));
      chk($sformatf("rnd%0d_data", r), row_data, er);
      lat_hi();
      chk($sformatf("rnd%0d_drop", r), {191'b0, row_valid}, '0);
    end
    chk("rnd_errs", {189'b0, err_short, err_overrun, err_protocol}, '0);

    // overrun then accept
    do_reset();
    for (int i = 0; i < COLUMNS; i++) shift1(6'($urandom));
    lat_lo(3'd1);
    lat_hi();
    for (int i = 0; i < COLUMNS; i++) shift1(6'($urandom));
    er = exp_row();
    lat_lo(3'd4);
    chk("ovr_flag", {191'b0, err_overrun}, 192'd1);
    chk("ovr_data", row_data, er);
    chk("ovr_idx", {189'b0, row_idx}, 192'd4);
    lat_hi();
    row_ready = 1;
    @(posedge clk);
    #1;
    chk("ovr_accept_drop", {191'b0, row_valid}, '0);
    row_ready = 0;

    // latch and accept in the same cycle
    do_reset();
    for (int i = 0; i < COLUMNS; i++) shift1(6'($urandom));
    lat_lo(3'd2);
    lat_hi();
    for (int i = 0; i < COLUMNS; i++) shift1(6'($urandom));
    er = exp_row();
    @(negedge clk);
    addr = 3'd6; lat = 0; row_ready = 1;
    @(posedge clk);
    #1;
    chk("same_valid", {191'b0, row_valid}, 192'd1);
    chk("same_ovr", {191'b0, err_overrun}, '0);
    chk("same_data", row_data, er);
    row_ready = 0;
    lat_hi();

    // dwell timing and saturation
    do_reset();
    dwell_run(200);
    dwell_run(70000);

    // oclk edge during dwell is a protocol error and not counted
    do_reset();
    for (int i = 0; i < 10; i++) shift1(6'($urandom));
    @(negedge clk);
    oe = 0;
    @(negedge clk);
    rgb = 6'h3f; oclk = 1;
    @(negedge clk);
    oclk = 0;
    @(negedge clk);
    oe = 1;
    @(negedge clk);
    chk("proto_flag", {191'b0, err_protocol}, 192'd1);
    for (int i = 0; i < 22; i++) shift1(6'($urandom));
    er = exp_row();
    lat_lo(3'd5);
    chk("proto_col_valid", {191'b0, row_valid}, 192'd1);
    chk("proto_col_short", {191'b0, err_short}, '0);
    chk("proto_col_data", row_data, er);
    lat_hi();

    // reset mid-shift discards the partial row
    for (int i = 0; i < 10; i++) shift1(6'($urandom));
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1;
    hist.delete();
    for (int i = 0; i < COLUMNS; i++) shift1(6'($urandom));
    er = exp_row();
    lat_lo(3'd6);
    chk("post_valid", {191'b0, row_valid}, 192'd1);
    chk("post_idx", {189'b0, row_idx}, 192'd6);
    chk("post_data", row_data, er);
    chk("post_errs", {189'b0, err_short, err_overrun, err_protocol}, '0);
    lat_hi();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
